// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, word size,
// default memory size and the word-address legality check.
package dmem_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam int WORD_BYTES    = 4;
  localparam int MEM_BYTES_DEF = 1024;

  // Legal word address: aligned and the whole word fits inside the memory.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned mem_bytes);
    return (a[1:0] == 2'b00) && (a <= (mem_bytes - 32'(WORD_BYTES)));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first eligible port scanning upward from
// last+1 with wrap. Masked ports are never eligible.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] elig;
  assign elig = req_i & ~mask_i;

  always_comb begin
    int p;
    p       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      p = (int'(last_i) + k) % NREQ;
      if (!any_o && elig[p]) begin
        any_o      = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NREQ requesters.
// Two-state FSM: IDLE arbitrates and latches, ACCESS drives the memory for one cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*32-1:0] addr,
  input  logic [NREQ*32-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic               memread,
  output logic               memwrite,
  output logic [31:0]        dataaddress,
  output logic [31:0]        writedata,
  input  logic [31:0]        data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][31:0] addr_v, wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  state_e          state_q;
  logic [IW-1:0]   last_q, win_q;
  logic            we_q, bad_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            memread_q, memwrite_q;
  logic [31:0]     daddr_q, wdout_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            gany, sel_ok;

  // The port acked this cycle still shows its old req; keep it out of arbitration.
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req),
    .mask_i  (ack_q),
    .last_i  (last_q),
    .grant_o (gnt),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign sel_ok = addr_ok(addr_v[gidx], MEM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      win_q      <= '0;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      daddr_q    <= '0;
      wdout_q    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gany) begin
            win_q      <= gidx;
            last_q     <= gidx;
            we_q       <= we[gidx];
            bad_q      <= ~sel_ok;
            memread_q  <= sel_ok & ~we[gidx];
            memwrite_q <= sel_ok & we[gidx];
            daddr_q    <= sel_ok ? addr_v[gidx] : 32'h0;
            wdout_q    <= wdata_v[gidx];
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ack_q      <= NREQ'(1) << win_q;
          err_q      <= bad_q;
          if (!bad_q && !we_q) rdata_q <= data;
          memread_q  <= 1'b0;
          memwrite_q <= 1'b0;
          daddr_q    <= '0;
          wdout_q    <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q == ACCESS);
  assign memread     = memread_q;
  assign memwrite    = memwrite_q;
  assign dataaddress = daddr_q;
  assign writedata   = wdout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// two-port run checked against a word-array reference memory.
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int MEMB = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we;
  logic [63:0]     addr, wdata;
  logic [1:0]      ack;
  logic            err, busy, memread, memwrite;
  logic [31:0]     rdata, dataaddress, writedata, data;

  int n_chk = 0;
  int n_fail = 0;

  dmem_arbiter #(.NREQ(NREQ), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .memread(memread),
    .memwrite(memwrite), .dataaddress(dataaddress), .writedata(writedata),
    .data(data)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on negedge; bench pokes go through here too.
  logic [31:0] mem [256];
  logic        fill_en = 1'b0, poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign data = (dataaddress < 32'(MEMB)) ? mem[dataaddress[9:2]] : 32'h0;

  always @(negedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (memwrite && dataaddress < 32'(MEMB)) begin
      mem[dataaddress[9:2]] <= writedata;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = 8'(idx); poke_val = val; poke_en = 1'b1;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p*32 +: 32] = a; wdata[p*32 +: 32] = d;
  endtask

  // Drives one request and waits (bounded) for its ack; returns what was observed.
  task automatic run_single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int rd, output int wr, output int anz,
                            output logic [1:0] ackv, output logic e, output logic [31:0] rdv);
    set_port(p, w, a, d);
    lat = 0; rd = 0; wr = 0; anz = 0; ackv = '0;
    while (lat < 10 && ackv == 2'b00) begin
      tick; lat++;
      if (memread) rd++;
      if (memwrite) wr++;
      if (dataaddress != 0) anz++;
      ackv = ack;
    end
    e = err; rdv = rdata;
    req[p] = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    fill_en = 1'b1;
    @(negedge clk); #1;
    fill_en = 1'b0;
    n_chk++;
    if ({ack, err, rdata, busy, memread, memwrite, dataaddress, writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b err=%b rdata=%h busy=%b rd=%b wr=%b da=%h wd=%h, want all 0",
               ack, err, rdata, busy, memread, memwrite, dataaddress, writedata);
    end
    @(negedge clk); rst = 1'b0;
    tick;
  endtask

  task automatic test_single_load;
    int lat, rd, wr, anz; logic [1:0] av; logic e; logic [31:0] rv;
    poke(0, 32'h0000_0015);
    run_single(0, 1'b0, 32'h0, 32'h0, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (lat !== 2 || rd !== 1 || wr !== 0) begin
      n_fail++; $display("FAIL single_load_timing: lat=%0d rd=%0d wr=%0d, want 2/1/0", lat, rd, wr);
    end
    n_chk++;
    if (av !== 2'b01 || e !== 1'b0 || rv !== 32'h15) begin
      n_fail++; $display("FAIL single_load_result: ack=%b err=%b rdata=%h, want 01/0/00000015", av, e, rv);
    end
  endtask

  task automatic test_store_load;
    int lat, rd, wr, anz; logic [1:0] av; logic e; logic [31:0] rv;
    poke(2, 32'h5555_5555);
    run_single(1, 1'b1, 32'h8, 32'hAB, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (wr !== 1 || rd !== 0 || av !== 2'b10 || e !== 1'b0) begin
      n_fail++; $display("FAIL store_p1: wr=%0d rd=%0d ack=%b err=%b, want 1/0/10/0", wr, rd, av, e);
    end
    n_chk++;
    if (mem[2] !== 32'hAB) begin
      n_fail++; $display("FAIL store_mem: mem[8]=%h, want 000000ab", mem[2]);
    end
    run_single(1, 1'b0, 32'h8, 32'h0, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (rv !== 32'hAB || av !== 2'b10 || e !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL load_back_p1: rdata=%h ack=%b err=%b lat=%0d, want ab/10/0/2", rv, av, e, lat);
    end
  endtask

  task automatic test_errors;
    int lat, rd, wr, anz; logic [1:0] av; logic e; logic [31:0] rv;
    poke(255, 32'h7777_7777);
    run_single(0, 1'b0, 32'h6, 32'h0, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (e !== 1'b1 || av !== 2'b01 || rd + wr + anz != 0 || rv !== 32'hAB) begin
      n_fail++; $display("FAIL misaligned_load: err=%b ack=%b ctl=%0d rdata=%h, want 1/01/0/ab", e, av, rd + wr + anz, rv);
    end
    run_single(1, 1'b1, 32'h3FE, 32'hFFFF_FFFF, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (e !== 1'b1 || av !== 2'b10 || rd + wr + anz != 0 || mem[255] !== 32'h7777_7777) begin
      n_fail++; $display("FAIL oor_store: err=%b ack=%b ctl=%0d mem=%h, want 1/10/0/77777777", e, av, rd + wr + anz, mem[255]);
    end
    run_single(0, 1'b1, 32'h3FC, 32'h1234_5678, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (e !== 1'b0 || wr !== 1 || mem[255] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL top_word_store: err=%b wr=%0d mem=%h, want 0/1/12345678", e, wr, mem[255]);
    end
    run_single(1, 1'b0, 32'h400, 32'h0, lat, rd, wr, anz, av, e, rv);
    n_chk++;
    if (e !== 1'b1 || rd !== 0 || rv !== 32'hAB) begin
      n_fail++; $display("FAIL oor_load: err=%b rd=%0d rdata=%h, want 1/0/ab", e, rd, rv);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] order [2];
    int n, cyc;
    poke(4, 32'h0000_1111);
    set_port(0, 1'b1, 32'h10, 32'hDEAD);
    tick;
    n_chk++;
    if (memwrite !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_access_enter: memwrite=%b busy=%b, want 1/1", memwrite, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (memwrite !== 1'b0 || busy !== 1'b0 || dataaddress !== 32'h0 || ack !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: memwrite=%b busy=%b da=%h ack=%b, want 0/0/0/00", memwrite, busy, dataaddress, ack);
    end
    req = '0;
    @(negedge clk); #1;
    n_chk++;
    if (mem[4] !== 32'h0000_1111) begin
      n_fail++; $display("FAIL lost_write: mem[0x10]=%h, want 00001111", mem[4]);
    end
    @(negedge clk); rst = 1'b0;
    set_port(0, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b0, 32'h8, 32'h0);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 16) begin
      tick; cyc++;
      if (ack != 2'b00) begin
        order[n] = ack; n++;
        req = req & ~ack;
      end
    end
    n_chk++;
    if (n !== 2 || order[0] !== 2'b01 || order[1] !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_order: acks=%0d first=%b second=%b, want 2/01/10", n, order[0], order[1]);
    end
    tick;
  endtask

  task automatic test_rerequest;
    int t [3];
    int n, cyc, bad;
    set_port(0, 1'b0, 32'h0, 32'h0);
    n = 0; cyc = 0; bad = 0;
    while (n < 3 && cyc < 30) begin
      tick; cyc++;
      if (ack != 2'b00) begin
        if (ack !== 2'b01 || err !== 1'b0) bad++;
        t[n] = cyc; n++;
      end
    end
    req = '0;
    tick; tick;
    n_chk++;
    if (n !== 3 || bad != 0 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      n_fail++; $display("FAIL rerequest_spacing: acks=%0d bad=%0d gaps=%0d,%0d, want 3/0/3,3", n, bad, t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_back_to_back;
    int seq [8];
    int n, cyc, c0, c1, bad, alt_bad;
    set_port(0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 32'h0, 32'h0);
    n = 0; cyc = 0; bad = 0; alt_bad = 0;
    while (n < 8 && cyc < 40) begin
      tick; cyc++;
      if (ack != 2'b00) begin
        if (!$onehot(ack) || err !== 1'b0 || rdata !== 32'h15) bad++;
        seq[n] = ack[1] ? 1 : 0;
        if (n > 0 && seq[n] == seq[n-1]) alt_bad++;
        n++;
      end
    end
    req = '0;
    tick; tick;
    c0 = 0; c1 = 0;
    for (int i = 0; i < n; i++) if (seq[i] == 0) c0++; else c1++;
    n_chk++;
    if (n !== 8 || alt_bad != 0 || c0 != 4 || c1 != 4 || bad != 0) begin
      n_fail++; $display("FAIL alternation: acks=%0d repeats=%0d p0=%0d p1=%0d bad=%0d, want 8/0/4/4/0", n, alt_bad, c0, c1, bad);
    end
  endtask

  task automatic test_random;
    logic [31:0] refmem [256];
    logic        pend [2];
    logic        pw [2];
    logic [31:0] pa [2], pd [2];
    int          age [2];
    logic [31:0] exp_rdata;
    int          cyc, p, nack, bad, mism;
    logic        experr;
    for (int i = 0; i < 256; i++) refmem[i] = mem[i];
    exp_rdata = 32'h15;
    pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
    cyc = 0; nack = 0;
    while (cyc < 600 && (cyc < 400 || pend[0] || pend[1])) begin
      tick; cyc++;
      if (ack != 2'b00) begin
        nack++;
        n_chk++;
        if (!$onehot(ack)) begin
          n_fail++; $display("FAIL rnd_onehot: ack=%b at cycle %0d", ack, cyc);
        end
        p = ack[1] ? 1 : 0;
        experr = (pa[p] % 4 != 0) || (pa[p] > 32'(MEMB - 4));
        if (!experr) begin
          if (pw[p]) refmem[pa[p] / 4] = pd[p];
          else exp_rdata = refmem[pa[p] / 4];
        end
        n_chk++;
        if (!pend[p] || err !== experr || rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL rnd_ack: port=%0d pend=%b addr=%h we=%b err=%b/%b rdata=%h/%h (got/want)",
                   p, pend[p], pa[p], pw[p], err, experr, rdata, exp_rdata);
        end
        pend[p] = 0; req[p] = 1'b0;
      end
      for (int q = 0; q < 2; q++) begin
        if (pend[q]) begin
          age[q]++;
          if (age[q] == 9) begin
            n_chk++; n_fail++;
            $display("FAIL rnd_starvation: port %0d waited %0d cycles", q, age[q]);
          end
        end else if (cyc < 400 && $urandom_range(0, 1) == 1) begin
          pend[q] = 1; age[q] = 0;
          pw[q] = 1'($urandom_range(0, 1));
          pd[q] = $urandom;
          case ($urandom_range(0, 9))
            0: pa[q] = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            1: pa[q] = 32'(MEMB) + 32'($urandom_range(0, 63)) * 4;
            2: pa[q] = 32'(MEMB - 4);
            default: pa[q] = 32'($urandom_range(0, 31)) * 4;
          endcase
          set_port(q, pw[q], pa[q], pd[q]);
        end
      end
    end
    tick; tick;
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) mism++;
    bad = (busy !== 1'b0) ? 1 : 0;
    n_chk++;
    if (mism != 0 || bad != 0 || nack < 50) begin
      n_fail++; $display("FAIL rnd_final: mem_mismatch=%0d busy=%b acks=%0d, want 0/0/>=50", mism, busy, nack);
    end
  endtask

  initial begin
    test_reset;
    test_single_load;
    test_store_load;
    test_errors;
    test_reset_mid;
    test_rerequest;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
